// File: rtl/execute_muldiv_if.sv
// Execute-stage handshake bundle for the M-extension unit: operands, forwarding
// sources, op select and the stall/result return path.
interface execute_muldiv_if #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
);
  logic                     in_valid;
  logic                     flush;
  logic [2:0]               funct3;
  logic [4:0]               rs1;
  logic [4:0]               rs2;
  logic [XLEN-1:0]          reg_A;
  logic [XLEN-1:0]          reg_B;
  logic [5*NUM_FWD-1:0]     fwd_rd;
  logic [NUM_FWD-1:0]       fwd_we;
  logic [XLEN*NUM_FWD-1:0]  fwd_data;
  logic                     stall;
  logic                     result_valid;
  logic [XLEN-1:0]          result;

  modport master (
    output in_valid, flush, funct3, rs1, rs2, reg_A, reg_B, fwd_rd, fwd_we, fwd_data,
    input  stall, result_valid, result
  );

  modport slave (
    input  in_valid, flush, funct3, rs1, rs2, reg_A, reg_B, fwd_rd, fwd_we, fwd_data,
    output stall, result_valid, result
  );
endinterface

// File: rtl/execute_muldiv.sv
// Iterative RV M-extension unit: one-bit-per-cycle shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up on the way out.
module execute_muldiv #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input logic             clk,
  input logic             rst_n,
  execute_muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [XLEN-1:0]   op_a, op_b;
  logic              hit_a, hit_b;
  logic              accept;
  logic              is_div, a_sgn, b_sgn, sa, sb;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   a_mag, b_mag, special_res;
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] step, fix_prod;
  logic [XLEN-1:0]   fix_quot, fix_rem, final_res;

  // Lowest-index matching source wins; x0 never forwards.
  always_comb begin
    op_a  = bus.reg_A;
    op_b  = bus.reg_B;
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int unsigned i = 0; i < NUM_FWD; i++) begin
      if (!hit_a && bus.fwd_we[i] && bus.fwd_rd[5*i +: 5] == bus.rs1 && bus.rs1 != '0) begin
        op_a  = bus.fwd_data[XLEN*i +: XLEN];
        hit_a = 1'b1;
      end
      if (!hit_b && bus.fwd_we[i] && bus.fwd_rd[5*i +: 5] == bus.rs2 && bus.rs2 != '0) begin
        op_b  = bus.fwd_data[XLEN*i +: XLEN];
        hit_b = 1'b1;
      end
    end
  end

  always_comb begin
    accept   = (state_q == IDLE) && bus.in_valid && !bus.flush;
    is_div   = bus.funct3[2];
    a_sgn    = is_div ? ~bus.funct3[0] : ~(bus.funct3[1] & bus.funct3[0]);
    b_sgn    = is_div ? ~bus.funct3[0] : ~bus.funct3[1];
    sa       = a_sgn & op_a[XLEN-1];
    sb       = b_sgn & op_b[XLEN-1];
    a_mag    = sa ? -op_a : op_a;
    b_mag    = sb ? -op_b : op_b;
    div_zero = is_div && (op_b == '0);
    div_ovf  = is_div && !bus.funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_res = bus.funct3[1] ? op_a : '1;
    else          special_res = bus.funct3[1] ? '0   : op_a;
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    if (op_q[2])
      step = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                             : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else
      step = {mul_sum, acc_q[XLEN-1:1]};
    fix_prod = neg_q  ? -step : step;
    fix_quot = neg_q  ? -step[XLEN-1:0] : step[XLEN-1:0];
    fix_rem  = rneg_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
    case (op_q)
      3'd0:             final_res = fix_prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: final_res = fix_prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       final_res = fix_quot;
      default:          final_res = fix_rem;
    endcase
  end

  always_comb begin
    op_d     = op_q;
    b_d      = b_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (accept) begin
        op_d   = bus.funct3;
        b_d    = b_mag;
        acc_d  = {{XLEN{1'b0}}, a_mag};
        neg_d  = sa ^ sb;
        rneg_d = sa;
        cnt_d  = CW'(XLEN);
        if (special) result_d = special_res;
      end
      RUN: if (!bus.flush) begin
        acc_d = step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) result_d = final_res;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = special ? DONE : RUN;
      RUN:     if (bus.flush) state_d = IDLE;
               else if (cnt_q == CW'(1)) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.stall        = 1'b0;
    bus.result_valid = 1'b0;
    case (state_q)
      IDLE:    bus.stall = bus.in_valid & ~bus.flush;
      RUN:     bus.stall = 1'b1;
      default: bus.result_valid = 1'b1;
    endcase
    bus.result = result_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_execute_muldiv.sv
// Directed + randomised bench for execute_muldiv with a result scoreboard.
module tb_execute_muldiv;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
    int          lat;
  } exp_t;
  exp_t sbq[$];

  execute_muldiv_if #(.XLEN(32), .NUM_FWD(2)) bus ();
  execute_muldiv #(.XLEN(32), .NUM_FWD(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sbv = longint'($signed(b));
    longint      ub = longint'({32'b0, b});
    logic [63:0] p;
    logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sbv; return p[31:0]; end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  // Presents an op just after a rising edge, then follows it to its result.
  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic [31:0] ra, input logic [31:0] rb,
                        input logic [9:0] frd, input logic [1:0] fwe, input logic [63:0] fdat,
                        input logic [31:0] exp_val, input int exp_lat);
    int   n;
    int   low;
    exp_t e;
    bus.funct3 = f3;  bus.rs1 = r1;  bus.rs2 = r2;
    bus.reg_A = ra;   bus.reg_B = rb;
    bus.fwd_rd = frd; bus.fwd_we = fwe; bus.fwd_data = fdat;
    bus.in_valid = 1'b1;
    e.tag = tag; e.val = exp_val; e.lat = exp_lat;
    sbq.push_back(e);
    #1;
    check({tag, " stall@accept"}, 64'(bus.stall), 64'd1);
    @(posedge clk); #1;
    bus.reg_A = $urandom; bus.reg_B = $urandom;
    bus.fwd_data = {$urandom, $urandom};
    n = 1; low = 0;
    while (!bus.result_valid && n < 200) begin
      if (!bus.stall) low++;
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    e = sbq.pop_front();
    check({e.tag, " latency"}, 64'(n), 64'(e.lat));
    check({e.tag, " result"}, 64'(bus.result), 64'(e.val));
    check({e.tag, " stall-drops"}, 64'(low), 64'd0);
    check({e.tag, " stall@done"}, 64'(bus.stall), 64'd0);
    @(posedge clk); #1;
    check({e.tag, " hold"}, {31'b0, bus.result_valid, bus.result}, {32'b0, e.val});
  endtask

  task automatic op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] exp_val, input int exp_lat);
    run_op(tag, f3, 5'd0, 5'd0, a, b, 10'd0, 2'b00, 64'd0, exp_val, exp_lat);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.funct3 = '0;
    bus.rs1 = '0; bus.rs2 = '0; bus.reg_A = '0; bus.reg_B = '0;
    bus.fwd_rd = '0; bus.fwd_we = '0; bus.fwd_data = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", {bus.stall, bus.result_valid, bus.result}, 34'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op("mul",      3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    op("mulhu",    3'd3, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 33);
    op("mulh",     3'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    op("mulhsu",   3'd2, 32'd2, 32'hFFFF_FFFD, 32'h0000_0001, 33);
    op("div",      3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33);
    op("rem",      3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33);
    op("divu",     3'd5, 32'd100, 32'd7, 32'd14, 33);
    op("remu",     3'd7, 32'd100, 32'd7, 32'd2, 33);
    op("div0",     3'd4, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
    op("rem0",     3'd6, 32'h1234, 32'd0, 32'h0000_1234, 1);
    op("divovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    op("removf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

    run_op("fwd-src0", 3'd0, 5'd5, 5'd0, 32'd1, 32'd2, {5'd5, 5'd5}, 2'b11, {32'd99, 32'd10}, 32'd20, 33);
    run_op("fwd-x0",   3'd0, 5'd0, 5'd0, 32'd1, 32'd2, {5'd0, 5'd0}, 2'b11, {32'd99, 32'd10}, 32'd2, 33);
    run_op("fwd-src1", 3'd0, 5'd5, 5'd0, 32'd1, 32'd2, {5'd5, 5'd5}, 2'b10, {32'd99, 32'd10}, 32'd198, 33);
    run_op("fwd-B",    3'd0, 5'd3, 5'd5, 32'd4, 32'd2, {5'd5, 5'd9}, 2'b11, {32'd9, 32'd77}, 32'd36, 33);

    // Flush in the tenth cycle after accept of a DIVU.
    bus.funct3 = 3'd5; bus.rs1 = '0; bus.rs2 = '0; bus.fwd_we = '0;
    bus.reg_A = 32'd1000; bus.reg_B = 32'd3; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    check("flush stall@t+10", 64'(bus.stall), 64'd1);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    #1;
    check("flush stall@t+11", {bus.stall, bus.result_valid}, 64'd0);
    op("mul-after-flush", 3'd0, 32'd3, 32'd4, 32'd12, 33);

    // Reset in the middle of a multiply.
    bus.funct3 = 3'd0; bus.reg_A = 32'd5; bus.reg_B = 32'd5; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0; bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("reset-in-run", {bus.stall, bus.result_valid, bus.result}, 34'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset idle", {bus.stall, bus.result_valid}, 64'd0);
    op("mul-after-reset", 3'd0, 32'd6, 32'd7, 32'd42, 33);

    for (int i = 0; i < 12; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      if (i == 7) b = 32'd0;
      op($sformatf("rand%0d_f%0d", i, f3), f3, a, b, model(f3, a, b), lat_of(f3, a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/execute_muldiv.md
Name: execute_muldiv

Overview:
- Parametrised multi-cycle execute unit for the RV M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits in the execute stage beside the single-cycle ALU path.
- Resolves operand forwarding from NUM_FWD older pipeline stages.
- Latches the operands and runs an iterative one-bit-per-cycle multiply or divide, holding the pipeline with `stall` until the result is ready.

Parameters:
- XLEN, 32, datapath width; must be even and ≥ 8.
- NUM_FWD, 2, number of forwarding sources; index 0 is the youngest and has the highest priority.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  M-op present in execute; held high with stable inputs while `stall`=1.
- flush  in  1  kill the in-flight op.
- funct3  in  3  op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1, rs2  in  5 each  source register indices.
- reg_A, reg_B  in  XLEN each  register-file read data.
- fwd_rd  in  5*NUM_FWD  destination index per source; source i occupies bits [5i+4:5i].
- fwd_we  in  NUM_FWD  write-enable per source.
- fwd_data  in  XLEN*NUM_FWD  forwarded value per source.
- stall  out  1  freeze upstream stages.
- result_valid  out  1  one-cycle pulse; `result` is valid in this cycle.
- result  out  XLEN  op result.

Behaviour:
- Forwarding (combinational):
  - Operand A = fwd_data[i] for the lowest i with fwd_we[i] & (fwd_rd[i]==rs1) & (rs1!=0); otherwise reg_A.
  - Operand B is resolved the same way using rs2.
  - x0 is never forwarded.
- States: IDLE, RUN, DONE.
- Reset (rst_n=0 at an edge):
  - state←IDLE; result, counter and datapath registers cleared to 0.
  - Overrides flush and in_valid.
- IDLE:
  - Entered from reset, and after DONE or a flush.
  - stall = in_valid & ~flush (combinational).
  - On in_valid & ~flush: latch the forwarded operands and funct3.
  - Special cases, which go to DONE next cycle:
    - Divisor 0: DIV/DIVU quotient = all ones; REM/REMU remainder = dividend.
    - Signed overflow (DIV/REM, dividend = −2^(XLEN−1), divisor = −1): quotient = dividend; remainder = 0.
  - All other ops go to RUN with counter=XLEN.
- RUN:
  - stall=1.
  - Multiply:
    - Unsigned shift-add on operand magnitudes into a 2*XLEN accumulator, one multiplier bit per cycle.
    - Signedness: MUL/MULH treat both operands as signed; MULHSU treats rs1 signed and rs2 unsigned; MULHU treats both as unsigned.
  - Divide: restoring division on magnitudes, one quotient bit per cycle; DIV/REM are signed, DIVU/REMU are unsigned.
  - Counter decrements each cycle; when it reaches 0, go to DONE.
- DONE (exactly one cycle):
  - result_valid=1, stall=0.
  - Sign fix-up, applied before output:
    - Product is negated if the operand signs differ.
    - Quotient is negated if the operand signs differ.
    - Remainder takes the sign of the dividend.
  - Result selection:
    - MUL: low XLEN bits of the product.
    - MULH/MULHSU/MULHU: high XLEN bits of the product.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - `result` is registered and holds its value until the next DONE.
  - Next state IDLE.
  - A new in_valid is not accepted in the DONE cycle; upstream advances on stall=0.
- Latency: accept at edge t → result_valid in cycle t+XLEN+1 for normal ops, t+1 for special cases. Back-to-back ops are separated by at least one IDLE cycle.
- Flush:
  - In IDLE: suppresses acceptance.
  - In RUN: next state IDLE, no result_valid; stall drops the cycle after flush.
  - In DONE: result_valid is still emitted; the consumer discards it.
- Operands are captured at accept only; later changes to the forward or register inputs are ignored.

Test Plan:
1. XLEN=32, MUL, A=7, B=−3 (0xFFFFFFFD) → stall high 33 cycles; result_valid at t+33; result=0xFFFFFFEB. MULHU on the same operands → 0x00000006.
2. DIV, A=−20, B=3 → quotient 0xFFFFFFFA (−6). REM on the same operands → 0xFFFFFFFE (−2). DIVU, 100/7 → 14, REMU → 2.
3. DIV with B=0, A=0x1234 → result_valid at t+1; result 0xFFFFFFFF. REM with B=0 → 0x1234. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0, both at t+1.
4. Forwarding: rs1=5, fwd_rd={5,5} with both fwd_we=1, fwd_data[0]=10, fwd_data[1]=99, reg_A=1; B=2; MUL → 20 (source 0 wins). Same setup with rs1=0 → uses reg_A. With fwd_we[0]=0 → uses 99 (result 198).
5. Flush asserted at cycle t+10 of a DIVU → no result_valid, stall low from t+11. A new MUL 3×4 accepted immediately after → 12 at +33.
6. rst_n low during RUN → next cycle state IDLE, stall=0, result=0, result_valid=0; a normal op works afterwards.
